// File: rtl/eth_frame_tx.sv
// ARP / UDP-over-IPv4 frame generator producing a 32-bit big-endian word stream.
// Oversized datagrams are split into IPv4 fragments separated by an idle gap.
module eth_frame_tx #(
    parameter int          FRAG_BYTES = 1400,
    parameter logic [15:0] SRC_PORT   = 16'd2179,
    parameter logic [15:0] DST_PORT   = 16'd5152,
    parameter logic [7:0]  IP_TTL     = 8'hC8,
    parameter int          GAP_CYCLES = 4,
    parameter int          ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_pkt_type,
    input  logic [15:0]       i_udp_len,
    input  logic [47:0]       i_self_mac,
    input  logic [47:0]       i_target_mac,
    input  logic [31:0]       i_self_ip,
    input  logic [31:0]       i_target_ip,
    output logic [31:0]       o_data,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic              o_sop,
    output logic              o_eop,
    output logic [1:0]        o_empty,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [31:0]       i_rd_data,
    output logic              o_busy,
    output logic              o_done
);
    localparam logic [15:0] FRAG   = 16'(FRAG_BYTES);
    localparam logic [15:0] GAP_LD = 16'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, CALC, SEND, GAP} state_t;
    state_t state;

    logic [1:0]  ptype, emp;
    logic [47:0] dmac, smac, tha;
    logic [31:0] sip, dip, word, mask;
    logic [15:0] ulen, ip_id, rem, off_b, tot, csum, nwords, idx, gap_cnt;
    logic [12:0] off13;
    logic        first, mf, is_udp, is_pay, xfer;

    logic [15:0] n_c, tot_c, csum_c, sum2;
    logic [19:0] sum0;
    logic [16:0] sum1;
    logic        mf_c;

    assign is_udp = (ptype == 2'd3);
    assign is_pay = is_udp && (idx >= (first ? 16'd12 : 16'd10));
    assign xfer   = o_vld && i_rdy;
    assign o_busy = (state != IDLE);
    assign o_done = xfer && o_eop && !mf;

    // Header of the fragment starting at byte offset off_b with rem bytes left
    always_comb begin
        mf_c   = rem > FRAG;
        n_c    = mf_c ? FRAG : rem;
        tot_c  = n_c + 16'd20;
        sum0   = 20'h04500 + 20'(tot_c) + 20'(ip_id) + 20'({2'b00, mf_c, off_b[15:3]})
               + 20'({IP_TTL, 8'h11}) + 20'(sip[31:16]) + 20'(sip[15:0])
               + 20'(dip[31:16]) + 20'(dip[15:0]);
        sum1   = 17'(sum0[15:0]) + 17'(sum0[19:16]);
        sum2   = sum1[15:0] + 16'(sum1[16]);
        csum_c = ~sum2;
    end

    always_comb begin
        tha  = (ptype == 2'd2) ? dmac : 48'h0;
        word = 32'h0;
        case (idx)
            16'd1:   word = {16'h0000, dmac[47:32]};
            16'd2:   word = dmac[31:0];
            16'd3:   word = smac[47:16];
            16'd4:   word = {smac[15:0], is_udp ? 16'h0800 : 16'h0806};
            default: ;
        endcase
        if (is_pay) begin
            word = i_rd_data;
        end else if (is_udp) begin
            case (idx)
                16'd5:   word = {8'h45, 8'h00, tot};
                16'd6:   word = {ip_id, 2'b00, mf, off13};
                16'd7:   word = {IP_TTL, 8'h11, csum};
                16'd8:   word = sip;
                16'd9:   word = dip;
                16'd10:  word = {SRC_PORT, DST_PORT};
                16'd11:  word = {ulen + 16'd8, 16'h0000};
                default: ;
            endcase
        end else begin
            case (idx)
                16'd5:   word = 32'h0001_0800;
                16'd6:   word = {8'h06, 8'h04, 8'h00, 6'b0, ptype};
                16'd7:   word = smac[47:16];
                16'd8:   word = {smac[15:0], sip[31:16]};
                16'd9:   word = {sip[15:0], tha[47:32]};
                16'd10:  word = tha[31:0];
                16'd11:  word = dip;
                default: ;
            endcase
        end
        // o_empty is nonzero only on eop, so this trims just the tail word
        mask = 32'hFFFF_FFFF << {o_empty, 3'b000};
    end

    assign o_data = o_vld ? (word & mask) : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptype     <= 2'd0;
            ulen      <= 16'd0;
            dmac      <= 48'h0;
            smac      <= 48'h0;
            sip       <= 32'h0;
            dip       <= 32'h0;
            ip_id     <= 16'd0;
            rem       <= 16'd0;
            off_b     <= 16'd0;
            first     <= 1'b0;
            tot       <= 16'd0;
            mf        <= 1'b0;
            off13     <= 13'd0;
            csum      <= 16'd0;
            nwords    <= 16'd0;
            emp       <= 2'd0;
            idx       <= 16'd0;
            gap_cnt   <= 16'd0;
            o_vld     <= 1'b0;
            o_sop     <= 1'b0;
            o_eop     <= 1'b0;
            o_empty   <= 2'd0;
            o_rd_addr <= '0;
        end else begin
            case (state)
                IDLE: if (i_start && i_pkt_type != 2'd0) begin
                    ptype <= i_pkt_type;
                    ulen  <= i_udp_len;
                    dmac  <= i_target_mac;
                    smac  <= i_self_mac;
                    sip   <= i_self_ip;
                    dip   <= i_target_ip;
                    rem   <= i_udp_len + 16'd8;
                    off_b <= 16'd0;
                    first <= 1'b1;
                    state <= CALC;
                end
                CALC: begin
                    tot   <= tot_c;
                    mf    <= is_udp && mf_c;
                    off13 <= off_b[15:3];
                    csum  <= csum_c;
                    if (is_udp) begin
                        nwords    <= 16'd9 + ((n_c + 16'd3) >> 2);
                        emp       <= 2'd0 - n_c[1:0];
                        o_rd_addr <= first ? '0 : ADDR_W'((off_b - 16'd8) >> 2);
                    end else begin
                        nwords <= 16'd11;
                        emp    <= 2'd0;
                    end
                    idx     <= 16'd1;
                    o_vld   <= 1'b1;
                    o_sop   <= 1'b1;
                    o_eop   <= 1'b0;
                    o_empty <= 2'd0;
                    state   <= SEND;
                end
                SEND: if (xfer) begin
                    if (is_pay) o_rd_addr <= o_rd_addr + ADDR_W'(1);
                    if (o_eop) begin
                        o_vld   <= 1'b0;
                        o_sop   <= 1'b0;
                        o_eop   <= 1'b0;
                        o_empty <= 2'd0;
                        if (mf) begin
                            rem   <= rem - FRAG;
                            off_b <= off_b + FRAG;
                            first <= 1'b0;
                        end else if (is_udp) begin
                            ip_id <= ip_id + 16'd1;
                        end
                        if (GAP_CYCLES == 0) begin
                            state <= mf ? CALC : IDLE;
                        end else begin
                            gap_cnt <= GAP_LD;
                            state   <= GAP;
                        end
                    end else begin
                        idx   <= idx + 16'd1;
                        o_sop <= 1'b0;
                        if (idx + 16'd1 == nwords) begin
                            o_eop   <= 1'b1;
                            o_empty <= emp;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'd0) state <= mf ? CALC : IDLE;
                    else gap_cnt <= gap_cnt - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx: ARP, UDP, fragmentation, stalls, ignored
// starts and mid-frame reset, against hand-computed word values.
module tb_eth_frame_tx;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_start = 1'b0, i_rdy = 1'b1;
    logic [1:0]  i_pkt_type = 2'd0;
    logic [15:0] i_udp_len = 16'd0;
    logic [47:0] i_self_mac = 48'h02_00_00_00_00_01, i_target_mac = 48'h0;
    logic [31:0] i_self_ip = 32'hC0A8010A, i_target_ip = 32'hC0A80101;
    logic [31:0] o_data, i_rd_data;
    logic        o_vld, o_sop, o_eop, o_busy, o_done;
    logic [1:0]  o_empty;
    logic [9:0]  o_rd_addr;

    eth_frame_tx dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_pkt_type(i_pkt_type),
        .i_udp_len(i_udp_len), .i_self_mac(i_self_mac), .i_target_mac(i_target_mac),
        .i_self_ip(i_self_ip), .i_target_ip(i_target_ip), .o_data(o_data), .o_vld(o_vld),
        .i_rdy(i_rdy), .o_sop(o_sop), .o_eop(o_eop), .o_empty(o_empty),
        .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Packet RAM model: word at address a reads as CAFE_00aa
    assign i_rd_data = {16'hCAFE, 6'b0, o_rd_addr};

    localparam logic [47:0] TMAC = 48'h00_11_22_33_44_55;

    int checks = 0, errors = 0;
    logic [31:0] fw [512];
    logic [9:0]  fa [512];
    logic [1:0]  f_emp;
    logic        f_done;
    int t_sop, t_eop, stall_bad, vld_drop, bad_done, sop_bad;

    task automatic start_pkt(input logic [1:0] t, input logic [15:0] len, input logic [47:0] tmac);
        @(negedge clk);
        i_pkt_type = t; i_udp_len = len; i_target_mac = tmac; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (!o_busy) return;
        end
    endtask

    // Collects one frame; records protocol violations in the counters above
    task automatic get_frame(input bit rnd, output int nw, output int wait_c, output bit tmo);
        bit stalled;
        logic [31:0] sd;
        logic [9:0] sa;
        logic [1:0] se;
        logic ss, sq;
        nw = 0; wait_c = 0; tmo = 1'b0; stalled = 1'b0;
        f_emp = 2'd0; f_done = 1'b0;
        stall_bad = 0; vld_drop = 0; bad_done = 0; sop_bad = 0;
        sd = 32'h0; sa = 10'h0; se = 2'd0; ss = 1'b0; sq = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            i_rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (!o_vld) begin
                if (nw > 0 || stalled) vld_drop++;
                wait_c++;
                continue;
            end
            if (stalled && (o_data !== sd || o_rd_addr !== sa || o_empty !== se ||
                            o_sop !== ss || o_eop !== sq)) stall_bad++;
            if (nw == 0 && !stalled) t_sop = cyc;
            if (!i_rdy) begin
                stalled = 1'b1;
                sd = o_data; sa = o_rd_addr; se = o_empty; ss = o_sop; sq = o_eop;
                if (o_done) bad_done++;
            end else begin
                stalled = 1'b0;
                if (o_sop !== (nw == 0)) sop_bad++;
                if (o_done && !o_eop) bad_done++;
                fw[nw] = o_data; fa[nw] = o_rd_addr; nw++;
                if (o_eop) begin
                    f_emp = o_empty; f_done = o_done; t_eop = cyc;
                    return;
                end
            end
        end
        tmo = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({o_vld, o_sop, o_eop, o_done, o_busy} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {o_vld, o_sop, o_eop, o_done, o_busy});
        end
        checks++;
        if (o_empty !== 2'd0) begin errors++; $display("FAIL reset_empty got %0d want 0", o_empty); end
        checks++;
        if (o_rd_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", o_rd_addr); end
        checks++;
        if (o_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", o_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arp(input logic [1:0] t, input logic [47:0] tmac, input logic [31:0] e [11]);
        int nw, wc; bit tmo;
        start_pkt(t, 16'd0, tmac);
        #1;
        checks++;
        if (!(o_busy === 1'b1 && o_vld === 1'b0)) begin
            errors++; $display("FAIL arp_calc busy=%b vld=%b want busy=1 vld=0", o_busy, o_vld);
        end
        get_frame(1'b0, nw, wc, tmo);
        checks++;
        if (tmo || wc !== 0 || nw !== 11) begin
            errors++; $display("FAIL arp_len tmo=%0d wait=%0d words=%0d want 0/0/11", tmo, wc, nw);
        end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (fw[i] !== e[i]) begin errors++; $display("FAIL arp_w%0d got %h want %h", i + 1, fw[i], e[i]); end
        end
        checks++;
        if (f_emp !== 2'd0 || f_done !== 1'b1 || sop_bad !== 0 || bad_done !== 0) begin
            errors++; $display("FAIL arp_eop empty=%0d done=%b sop_bad=%0d bad_done=%0d want 0/1/0/0",
                               f_emp, f_done, sop_bad, bad_done);
        end
        wait_idle();
    endtask

    task automatic test_udp16(input bit rnd, input logic [31:0] w6, input logic [31:0] w7, input string nm);
        int nw, wc; bit tmo;
        logic [31:0] e [15] = '{32'h00000011, 32'h22334455, 32'h02000000, 32'h00010800,
                                32'h4500002C, 32'h0, 32'h0, 32'hC0A8010A, 32'hC0A80101,
                                32'h08831420, 32'h00180000, 32'hCAFE0000, 32'hCAFE0001,
                                32'hCAFE0002, 32'hCAFE0003};
        e[5] = w6; e[6] = w7;
        start_pkt(2'd3, 16'd16, TMAC);
        get_frame(rnd, nw, wc, tmo);
        checks++;
        if (tmo || nw !== 15) begin errors++; $display("FAIL %s_len tmo=%0d words=%0d want 15", nm, tmo, nw); end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (fw[i] !== e[i]) begin errors++; $display("FAIL %s_w%0d got %h want %h", nm, i + 1, fw[i], e[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fa[11 + i] !== 10'(i)) begin
                errors++; $display("FAIL %s_addr%0d got %0d want %0d", nm, i, fa[11 + i], i);
            end
        end
        checks++;
        if (f_emp !== 2'd0 || f_done !== 1'b1 || stall_bad !== 0 || vld_drop !== 0 || bad_done !== 0) begin
            errors++; $display("FAIL %s_ctrl empty=%0d done=%b stall_bad=%0d vld_drop=%0d bad_done=%0d want 0/1/0/0/0",
                               nm, f_emp, f_done, stall_bad, vld_drop, bad_done);
        end
        wait_idle();
    endtask

    task automatic test_udp5();
        int nw, wc; bit tmo;
        logic [31:0] e [13] = '{32'h00000011, 32'h22334455, 32'h02000000, 32'h00010800,
                                32'h45000021, 32'h00010000, 32'hC8116F6F, 32'hC0A8010A,
                                32'hC0A80101, 32'h08831420, 32'h000D0000, 32'hCAFE0000,
                                32'hCA000000};
        start_pkt(2'd3, 16'd5, TMAC);
        get_frame(1'b0, nw, wc, tmo);
        checks++;
        if (tmo || nw !== 13) begin errors++; $display("FAIL udp5_len tmo=%0d words=%0d want 13", tmo, nw); end
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (fw[i] !== e[i]) begin errors++; $display("FAIL udp5_w%0d got %h want %h", i + 1, fw[i], e[i]); end
        end
        checks++;
        if (f_emp !== 2'd3 || f_done !== 1'b1) begin
            errors++; $display("FAIL udp5_eop empty=%0d done=%b want 3/1", f_emp, f_done);
        end
        wait_idle();
    endtask

    task automatic test_frag();
        int nw, wc, prev_eop, dones; bit tmo;
        int          enw [4] = '{359, 359, 359, 161};
        logic [31:0] ew5 [4] = '{32'h4500058C, 32'h4500058C, 32'h4500058C, 32'h45000274};
        logic [31:0] ew6 [4] = '{32'h00002000, 32'h000020AF, 32'h0000215E, 32'h0000020D};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0; prev_eop = 0;
        start_pkt(2'd3, 16'd4800, TMAC);
        for (int k = 0; k < 4; k++) begin
            get_frame(1'b0, nw, wc, tmo);
            checks++;
            if (tmo || nw !== enw[k]) begin
                errors++; $display("FAIL frag%0d_len tmo=%0d words=%0d want %0d", k, tmo, nw, enw[k]);
            end
            checks++;
            if (fw[4] !== ew5[k] || fw[5] !== ew6[k]) begin
                errors++; $display("FAIL frag%0d_hdr w5=%h w6=%h want %h %h", k, fw[4], fw[5], ew5[k], ew6[k]);
            end
            checks++;
            if (f_done !== (k == 3) || bad_done !== 0 || f_emp !== 2'd0) begin
                errors++; $display("FAIL frag%0d_done done=%b bad_done=%0d empty=%0d want %0d/0/0",
                                   k, f_done, bad_done, f_emp, k == 3);
            end
            if (f_done) dones++;
            if (k > 0) begin
                checks++;
                if (t_sop - prev_eop - 1 < 4) begin
                    errors++; $display("FAIL frag%0d_gap idle=%0d want >=4", k, t_sop - prev_eop - 1);
                end
            end
            if (k == 0) begin
                checks++;
                if (fw[358] !== 32'hCAFE015B) begin
                    errors++; $display("FAIL frag0_last got %h want CAFE015B", fw[358]);
                end
            end
            if (k == 1) begin
                checks++;
                if (fa[9] !== 10'd348 || fw[9] !== 32'hCAFE015C) begin
                    errors++; $display("FAIL frag1_addr addr=%0d data=%h want 348 CAFE015C", fa[9], fw[9]);
                end
            end
            if (k == 3) begin
                checks++;
                if (fw[6] !== 32'hC8116B10 || fw[160] !== 32'hCAFE00AF) begin
                    errors++; $display("FAIL frag3_tail w7=%h last=%h want C8116B10 CAFE00AF", fw[6], fw[160]);
                end
            end
            prev_eop = t_eop;
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL frag_dones got %0d want 1", dones); end
        wait_idle();
    endtask

    task automatic test_busy_start();
        int nw, wc, vseen; bit tmo;
        start_pkt(2'd3, 16'd16, TMAC);
        i_pkt_type = 2'd1; i_start = 1'b1;
        get_frame(1'b0, nw, wc, tmo);
        i_start = 1'b0;
        checks++;
        if (tmo || nw !== 15 || fw[3] !== 32'h00010800 || fw[5] !== 32'h00020000) begin
            errors++; $display("FAIL busy_frame words=%0d w4=%h w6=%h want 15 00010800 00020000", nw, fw[3], fw[5]);
        end
        vseen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (o_vld) vseen++;
        end
        checks++;
        if (vseen !== 0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL busy_ignored vld_cycles=%0d busy=%b want 0/0", vseen, o_busy);
        end
        @(negedge clk);
        i_pkt_type = 2'd0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL bad_type busy=%b want 0", o_busy); end
    endtask

    task automatic test_reset_mid();
        int n, nw, wc; bit tmo, hit;
        n = 0; hit = 1'b0;
        start_pkt(2'd3, 16'd1000, TMAC);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            i_rdy = 1'b1;
            #1;
            if (o_vld) begin
                n++;
                if (n == 100) begin
                    rst_n = 1'b0;
                    #1;
                    hit = 1'b1;
                    break;
                end
            end
        end
        checks++;
        if (!hit || o_vld !== 1'b0 || o_busy !== 1'b0 || o_eop !== 1'b0 || o_rd_addr !== 10'd0) begin
            errors++; $display("FAIL rst_mid hit=%b vld=%b busy=%b eop=%b addr=%0d want 1/0/0/0/0",
                               hit, o_vld, o_busy, o_eop, o_rd_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_pkt(2'd3, 16'd16, TMAC);
        get_frame(1'b0, nw, wc, tmo);
        checks++;
        if (tmo || nw !== 15 || fw[5] !== 32'h0 || fw[6] !== 32'hC8116F65 || f_done !== 1'b1) begin
            errors++; $display("FAIL rst_fresh words=%0d w6=%h w7=%h done=%b want 15 00000000 C8116F65 1",
                               nw, fw[5], fw[6], f_done);
        end
        wait_idle();
    endtask

    initial begin
        logic [31:0] arp_req [11] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h02000000, 32'h00010806,
                                      32'h00010800, 32'h06040001, 32'h02000000, 32'h0001C0A8,
                                      32'h010A0000, 32'h00000000, 32'hC0A80101};
        logic [31:0] arp_rep [11] = '{32'h00000011, 32'h22334455, 32'h02000000, 32'h00010806,
                                      32'h00010800, 32'h06040002, 32'h02000000, 32'h0001C0A8,
                                      32'h010A0011, 32'h22334455, 32'hC0A80101};
        test_reset();
        test_arp(2'd1, 48'hFFFF_FFFF_FFFF, arp_req);
        test_arp(2'd2, TMAC, arp_rep);
        test_udp16(1'b0, 32'h00000000, 32'hC8116F65, "udp16");
        test_udp5();
        test_frag();
        test_udp16(1'b1, 32'h00010000, 32'hC8116F64, "stall");
        test_busy_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
